// File: rtl/lsu_mem_master.sv
// Load/store unit memory master.
// Turns one CPU byte/half/word access into a single word request to memory.
// Store data is lane-replicated with byte strobes. Load data is aligned and
// sign- or zero-extended. Misaligned or illegal-size requests and memory
// timeouts come back as error responses.
module lsu_mem_master #(
  parameter int ADDR_WIDTH = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Last counter value before the timeout fires; the counter starts at 0 on WAIT entry.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [15:0] r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_valid;
  logic [3:0]  r_mem_wstrb;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_bad;

  // Byte strobes for a store at the given size and byte offset.
  function automatic logic [3:0] f_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Align the addressed bytes down to bit 0 and extend to 32 bits.
  function automatic logic [31:0] f_load(input logic [1:0] size, input logic uns,
                                         input logic [1:0] off, input logic [31:0] d);
    logic [31:0] s;
    logic [31:0] r;
    s = d >> {off, 3'b000};
    case (size)
      2'b00:   r = uns ? {24'd0, s[7:0]}  : {{24{s[7]}},  s[7:0]};
      2'b01:   r = uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  assign w_accept = req_valid && r_req_ready;
  assign w_bad    = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Address bits above the word index are not used by this master.
  generate
    if (ADDR_WIDTH < 30) begin : g_unused_addr
      logic w_unused_addr;
      assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];
    end
  endgenerate

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_off        <= 2'b00;
      r_cnt        <= 16'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_valid  <= 1'b0;
      r_mem_wstrb  <= 4'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_mem_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we   <= req_we;
            r_size <= req_size;
            r_uns  <= req_unsigned;
            r_off  <= req_addr[1:0];
            if (w_bad) begin
              // Rejected without touching memory; the block stays ready.
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= req_addr[ADDR_WIDTH+1:2];
              r_mem_wstrb <= req_we ? f_strb(req_size, req_addr[1:0]) : 4'b0000;
              r_mem_wdata <= f_wdata(req_size, req_wdata);
              r_req_ready <= 1'b0;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // mem_valid drops here, so it is only ever a one-cycle pulse.
          r_cnt   <= 16'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? 32'd0 : f_load(r_size, r_uns, r_off, mem_rdata);
            r_req_ready  <= 1'b1;
            r_cnt        <= 16'd0;
            r_state      <= S_IDLE;
          end else if (r_cnt == TO_LAST) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_req_ready  <= 1'b1;
            r_cnt        <= 16'd0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_valid  = r_mem_valid;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural word memory and a
// response scoreboard.
module tb_lsu_mem_master;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_valid;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic          mem_ready = 1'b0;

  lsu_mem_master #(.ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_valid(mem_valid), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int resp_count = 0;
  int exp_resps = 0;
  int resp_cyc = 0;
  int acc_cyc = 0;
  int mv_count = 0;
  logic prev_mv = 1'b0;
  logic [3:0]    last_wstrb;
  logic [31:0]   last_wdata;
  logic [AW-1:0] last_maddr;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // Memory model: captures on mem_valid, answers mem_lat cycles later.
  logic [31:0] mem [0:255];
  int          mem_lat = 1;
  logic        mem_en = 1'b1;
  int          pend = 0;
  logic [7:0]  cap_idx = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    mem_ready <= 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && mem_en) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[cap_idx];
      end
    end
    if (mem_valid) begin
      cap_idx = mem_addr[7:0];
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[cap_idx][8*b +: 8] = mem_wdata[8*b +: 8];
      pend = mem_lat;
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (mem_valid) begin
      mv_count++;
      last_wstrb = mem_wstrb;
      last_wdata = mem_wdata;
      last_maddr = mem_addr;
      check("mem_valid_pulse", {31'd0, prev_mv}, 32'd0);
    end
    prev_mv = mem_valid;
    if (resp_valid) begin
      exp_t e;
      resp_count++;
      resp_cyc = cyc;
      check("resp_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_rdata", resp_rdata, e.rdata);
      end
      check("ready_with_resp", {31'd0, req_ready}, 32'd1);
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic eerr, input logic [31:0] erd);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    exp_q.push_back('{err: eerr, rdata: erd});
    exp_resps++;
    acc_cyc = cyc;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (resp_count < exp_resps && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, resp_count, exp_resps);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    check({tag, "_mem_valid"},  {31'd0, mem_valid},  32'd0);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
  endtask

  initial begin
    int mv0;
    int rc0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'h8899AABB;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_maddr", {12'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Word load: address, strobes, single pulse and 3-cycle latency.
    mv0 = mv_count;
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b0, 32'h8899AABB);
    wait_resp("lw_done");
    check("lw_latency", resp_cyc - acc_cyc - 1, 32'd3);
    check("lw_maddr", {12'd0, last_maddr}, 32'h40);
    check("lw_wstrb", {28'd0, last_wstrb}, 32'd0);
    check("lw_pulses", mv_count - mv0, 32'd1);

    // Sub-word loads with sign and zero extension, sent back to back.
    send(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 1'b0, 32'hFFFFFF88);
    wait_resp("lb_done");
    send(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 1'b0, 32'h00000088);
    wait_resp("lbu_done");
    send(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 1'b0, 32'hFFFF8899);
    wait_resp("lh_done");
    send(1'b0, 2'b01, 1'b1, 32'h100, 32'd0, 1'b0, 32'h0000AABB);
    wait_resp("lhu_done");
    send(1'b0, 2'b00, 1'b0, 32'h100, 32'd0, 1'b0, 32'hFFFFFFBB);
    wait_resp("lb0_done");

    // Stores and readback.
    send(1'b1, 2'b00, 1'b0, 32'h201, 32'h123456CD, 1'b0, 32'd0);
    wait_resp("sb_done");
    check("sb_wstrb", {28'd0, last_wstrb}, 32'h2);
    check("sb_wdata", last_wdata, 32'hCDCDCDCD);
    check("sb_maddr", {12'd0, last_maddr}, 32'h80);
    send(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 1'b0, 32'd0);
    wait_resp("sh_done");
    check("sh_wstrb", {28'd0, last_wstrb}, 32'hC);
    check("sh_wdata", last_wdata, 32'hBEEFBEEF);
    send(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 1'b0, 32'hBEEFCD00);
    wait_resp("lw_rb_done");

    // Misaligned and illegal-size requests never reach memory.
    mv0 = mv_count;
    send(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 1'b1, 32'd0);
    wait_resp("mis_w_done");
    send(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 1'b1, 32'd0);
    wait_resp("size11_done");
    send(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 1'b1, 32'd0);
    wait_resp("mis_h_done");
    repeat (3) @(negedge clk);
    #1;
    check("err_no_mem", mv_count - mv0, 32'd0);

    // Memory that never answers: timeout after 8 WAIT cycles.
    mem_en = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b1, 32'd0);
    wait_resp("timeout_done");
    check("timeout_latency", resp_cyc - acc_cyc - 1, 32'd9);
    check("timeout_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    mem_en = 1'b1;

    // Reset during WAIT abandons the access; the late mem_ready is ignored.
    mem_lat = 4;
    rc0 = resp_count;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100;
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_idle_outputs("midrst");
    rst = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("midrst_no_resp", resp_count - rc0, 32'd0);
    mem_lat = 1;
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b0, 32'h8899AABB);
    wait_resp("post_rst_done");
    check("post_rst_latency", resp_cyc - acc_cyc - 1, 32'd3);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL provide parameter: ADDR_WIDTH, 20, word-index width of mem_addr.
REQ-002 SHALL provide parameter: TIMEOUT, 255, maximum cycles in WAIT before an error response (1..65535).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port: req_valid  input  1  CPU access request.
REQ-006 SHALL have port: req_ready  output  1  block idle; a request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-007 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port: req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port: req_unsigned  input  1  zero-extend load data when high.
REQ-010 SHALL have port: req_addr  input  32  byte address.
REQ-011 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port: resp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port: resp_rdata  output  32  extended load data (0 for stores and errors).
REQ-014 SHALL have port: resp_err  output  1  misaligned, illegal-size or timeout; valid with resp_valid.
REQ-015 SHALL have port: mem_valid  output  1  word request to memory, single-cycle pulse.
REQ-016 SHALL have port: mem_wstrb  output  4  byte write strobes; 0000 = read.
REQ-017 SHALL have port: mem_addr  output  ADDR_WIDTH  word index = req_addr[ADDR_WIDTH+1:2].
REQ-018 SHALL have port: mem_wdata  output  32  lane-replicated store data.
REQ-019 SHALL have port: mem_rdata  input  32  read word, little-endian.
REQ-020 SHALL have port: mem_ready  input  1  one-cycle completion pulse from memory.

Function
REQ-021 SHALL implement FSM IDLE, ISSUE, WAIT; all outputs registered; req_ready = (state == IDLE).
REQ-022 On acceptance in IDLE: SHALL capture req_* fields; a misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size-11 request SHALL produce resp_valid=1, resp_err=1, resp_rdata=0 in the next cycle with no memory access, staying in IDLE.
REQ-023 Legal request: SHALL go to ISSUE and drive mem_valid=1 for exactly one cycle with mem_addr, mem_wstrb, mem_wdata, then go to WAIT with mem_valid=0.
REQ-024 mem_valid SHALL never be high for two consecutive cycles (memory captures a fresh request on any cycle it sees mem_valid while idle).
REQ-025 Store strobes: byte -> 4'b0001 << addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111; loads -> 0000.
REQ-026 Store data: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-027 Load data: SHALL shift mem_rdata right by 8*addr[1:0], take 8/16/32 bits, sign-extend unless req_unsigned.
REQ-028 In WAIT, mem_ready=1 at an edge: SHALL pulse resp_valid=1 with resp_err=0 and resp_rdata (load) or 0 (store) in the next cycle, return to IDLE.
REQ-029 A 16-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; reaching TIMEOUT without mem_ready: resp_valid=1, resp_err=1, resp_rdata=0, return to IDLE.
REQ-030 mem_ready seen in IDLE or ISSUE SHALL be ignored.
REQ-031 Accepted request to first possible resp_valid: 3 cycles against a 1-cycle-delay memory (edge E0 accept, E1 memory capture, E2 mem_ready, resp_valid high after E3).
REQ-032 req_ready SHALL be high in the cycle resp_valid is high; back-to-back requests SHALL be accepted on that cycle.

Reset
REQ-033 While rst=0 at an edge: state=IDLE, req_ready=1 after reset, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0, wait counter=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no response pulse; a later mem_ready SHALL be ignored.

Verification
REQ-035 LW addr 0x100, memory word 0x8899AABB -> mem_addr=0x40, mem_wstrb=0000, single mem_valid pulse, resp_rdata=0x8899AABB 3 cycles after acceptance.
REQ-036 LB and LBU addr 0x103 on the same word -> resp_rdata 0xFFFFFF88 and 0x00000088; LH addr 0x102 -> 0xFFFF8899.
REQ-037 SB addr 0x201 wdata 0x123456CD -> mem_wstrb=0010, mem_wdata=0xCDCDCDCD; SH addr 0x202 wdata 0xBEEF -> 1100, 0xBEEFBEEF; readback LW -> 0xBEEFCD00 from zeroed word.
REQ-038 LW addr 0x102 and req_size=11 -> resp_err=1 next cycle, mem_valid never asserted.
REQ-039 Memory never asserts mem_ready, TIMEOUT=8 -> resp_err=1, resp_rdata=0 after 8 WAIT cycles, req_ready back high.
REQ-040 rst=0 one cycle during WAIT then late mem_ready -> no resp_valid; next LW completes normally.
